// File: rtl/kyber_poly_ram.sv
// True dual-port polynomial coefficient RAM with per-lane write masks and a
// word-per-cycle clear sequencer that runs after reset and on request.
module kyber_poly_ram #(
  parameter int unsigned COEF_W  = 16,
  parameter int unsigned LANES   = 2,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned OUT_REG = 1,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned DW     = LANES * COEF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_start,
  output logic                 busy,
  input  logic                 ena,
  input  logic                 enb,
  input  logic                 wea,
  input  logic                 web,
  input  logic [LANES-1:0]     wmaska,
  input  logic [LANES-1:0]     wmaskb,
  input  logic [AW-1:0]        addra,
  input  logic [AW-1:0]        addrb,
  input  logic signed [DW-1:0] dina,
  input  logic signed [DW-1:0] dinb,
  output logic signed [DW-1:0] douta,
  output logic signed [DW-1:0] doutb,
  output logic                 valida,
  output logic                 validb,
  output logic                 collision
);

  typedef enum logic {StClear, StIdle} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] mem [DEPTH];

  logic          rd_a, rd_b, wr_a, wr_b, same_addr;
  logic [DW-1:0] rda_q, rdb_q;
  logic          rva_q, rvb_q, coll_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StIdle:  if (clr_start) state_d = StClear;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == StClear);
  assign rd_a      = ena & ~wea & ~busy;
  assign rd_b      = enb & ~web & ~busy;
  assign wr_a      = ena & wea & ~busy;
  assign wr_b      = enb & web & ~busy;
  assign same_addr = (addra == addrb);

  // Storage is never reset; port A owns any lane both ports write at one address.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_a && wmaska[i]) begin
          mem[addra][i*COEF_W +: COEF_W] <= dina[i*COEF_W +: COEF_W];
        end
        if (wr_b && wmaskb[i] && !(wr_a && same_addr && wmaska[i])) begin
          mem[addrb][i*COEF_W +: COEF_W] <= dinb[i*COEF_W +: COEF_W];
        end
      end
    end
  end

  // Read registers sample the array before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rda_q  <= '0;
      rdb_q  <= '0;
      rva_q  <= 1'b0;
      rvb_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      rva_q  <= rd_a;
      rvb_q  <= rd_b;
      coll_q <= ~busy & ena & enb & same_addr & (wea | web);
      if (rd_a) rda_q <= mem[addra];
      if (rd_b) rdb_q <= mem[addrb];
    end
  end

  assign collision = coll_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] oa_q, ob_q;
    logic          va_q, vb_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        oa_q <= '0;
        ob_q <= '0;
        va_q <= 1'b0;
        vb_q <= 1'b0;
      end else begin
        va_q <= rva_q;
        vb_q <= rvb_q;
        if (rva_q) oa_q <= rda_q;
        if (rvb_q) ob_q <= rdb_q;
      end
    end

    assign douta  = oa_q;
    assign doutb  = ob_q;
    assign valida = va_q;
    assign validb = vb_q;
  end else begin : g_noreg
    assign douta  = rda_q;
    assign doutb  = rdb_q;
    assign valida = rva_q;
    assign validb = rvb_q;
  end

endmodule

// File: doc/kyber_poly_ram.md
KYBER_POLY_RAM -- requirements
Module: kyber_poly_ram

Interface
REQ-001 SHALL have parameter COEF_W, default 16: bits per coefficient.
REQ-002 SHALL have parameter LANES, default 2: coefficients packed per word.
REQ-003 SHALL have parameter DEPTH, default 128: words of storage; power of two, at least 4.
REQ-004 SHALL have parameter OUT_REG, default 1: 1 adds an output pipeline register, 0 omits it.
REQ-005 SHALL define derived AW = $clog2(DEPTH) and DW = LANES*COEF_W.
REQ-006 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have clr_start  input  1  one-cycle request to zero the whole memory.
REQ-009 SHALL have busy  output  1  high while the clear sequence runs.
REQ-010 SHALL have ena / enb  input  1 each  port enable.
REQ-011 SHALL have wea / web  input  1 each  write when enabled, read otherwise.
REQ-012 SHALL have wmaska / wmaskb  input  LANES each  per-lane write mask; lane i is bits [i*COEF_W +: COEF_W].
REQ-013 SHALL have addra / addrb  input  AW each  word address.
REQ-014 SHALL have dina / dinb  input signed  DW each  write data.
REQ-015 SHALL have douta / doutb  output signed  DW each  read data.
REQ-016 SHALL have valida / validb  output  1 each  read data valid strobe.
REQ-017 SHALL have collision  output  1  same-address conflict strobe.

Function
REQ-018 SHALL use true dual-port storage of DEPTH x DW; both ports are fully independent, read or write.
REQ-019 SHALL perform reads (en=1, we=0) with data on dout and valid=1 for one cycle: 1 cycle after the request edge when OUT_REG=0, 2 cycles when OUT_REG=1.
REQ-020 SHALL operate in no-change mode: on a write, or when the port is idle, dout holds its last value and valid=0.
REQ-021 SHALL, on a write, update only the lanes whose wmask bit is 1; with wmask=0, no storage changes.
REQ-022 SHALL, when ena=enb=1, addra=addrb and both ports write, store A data in lanes where wmaska=1, store B data in lanes where only wmaskb=1, and leave all other lanes unchanged.
REQ-023 SHALL, when one port reads and the other writes the same address in the same cycle, return the pre-write contents to the reading port.
REQ-024 SHALL pulse collision for one cycle, one cycle after any same-address request pair in which at least one port writes; read/read SHALL NOT set collision.
REQ-025 SHALL implement a two-state FSM, CLEAR and IDLE, with a clear address counter of width AW.
REQ-026 SHALL zero one word per cycle in CLEAR, at counter addresses 0..DEPTH-1.
REQ-027 SHALL go from CLEAR to IDLE after writing address DEPTH-1, and the counter SHALL return to 0.
REQ-028 SHALL go from IDLE to CLEAR on clr_start=1.
REQ-029 SHALL ignore clr_start while in CLEAR; the sequence SHALL NOT restart.
REQ-030 SHALL drive busy=1 exactly in CLEAR, for DEPTH consecutive cycles.
REQ-031 SHALL, while busy=1, ignore ena/enb completely: no write, no read, valid=0, collision=0.
REQ-032 SHALL, in the cycle clr_start is accepted, still serve port requests, since they precede the clear.
REQ-033 SHALL, when OUT_REG=1, let a read accepted just before CLEAR complete its pipeline with valid=1.

Reset
REQ-034 SHALL, on rst_n=0, immediately set douta=doutb=0, valida=validb=0, collision=0, pipeline registers=0, clear counter=0, FSM=CLEAR and busy=1.
REQ-035 SHALL run a full DEPTH-cycle clear after rst_n deasserts, then enter IDLE.
REQ-036 SHALL NOT reset memory contents asynchronously; an rst_n assertion mid-clear or mid-read SHALL discard in-flight reads and restart the clear from address 0.

Verification
REQ-037 SHALL cover clear after reset (defaults): release rst_n, count busy -> busy high exactly 128 cycles; then read addresses 0, 64 and 127 -> each returns 0 with valid at +2 cycles.
REQ-038 SHALL cover lane mask: A writes addr 5 with 0x1234_ABCD and mask 2'b11, then with 0x0000_7777 and mask 2'b01; A reads addr 5 -> 0x1234_7777.
REQ-039 SHALL cover write/write conflict: at addr 9, A writes 0x1111_2222 with mask 2'b01 and B writes 0x3333_4444 with mask 2'b11 in the same cycle -> stored 0x3333_2222; collision high exactly the next cycle.
REQ-040 SHALL cover read/write conflict: addr 3 holds 0x00AA_00BB; A reads while B writes 0x0CCC_0DDD -> A gets 0x00AA_00BB, a later read gets 0x0CCC_0DDD, and collision pulses once.
REQ-041 SHALL cover mid-clear behaviour: pulse clr_start in IDLE, then issue port writes and a second clr_start during busy -> writes discarded, busy stays high exactly 128 cycles total, all words read 0.
REQ-042 SHALL cover OUT_REG=0 with DEPTH=256 and COEF_W=12: read latency 1 cycle, busy 256 cycles; assert rst_n low at clear address 100 -> outputs 0 at once, and the clear restarts at 0 for a full 256 cycles.
